// File: rtl/maxpool_stage4.sv
// Per-channel max pooling of 16 x int8 sample vectors over POOL-sample windows,
// emitting NUM_OUT pooled vectors per started frame.
module maxpool_stage4 #(
  parameter int unsigned POOL    = 2,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned RELU    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic [127:0] out4,
  output logic         maxflag,
  output logic         done4,
  output logic         busy
);

  localparam int unsigned NCH = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned WCW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int unsigned OCW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(POOL - 1);
  localparam logic [OCW-1:0] OLAST = OCW'(NUM_OUT - 1);
  localparam bit RELU_EN = (RELU != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [WCW-1:0]             wcnt_q, wcnt_d;
  logic [OCW-1:0]             ocnt_q, ocnt_d;
  logic [NCH-1:0][DW-1:0]     max_q, max_d;
  logic [NCH-1:0][DW-1:0]     out4_q, out4_d;
  logic                       maxflag_q, maxflag_d;
  logic                       done4_q, done4_d;
  logic                       busy_q, busy_d;

  logic [NCH-1:0][DW-1:0]     in_vec;
  logic [NCH-1:0][DW-1:0]     samp;
  logic [NCH-1:0][DW-1:0]     cand;

  assign in_vec = in_data;

  // Clamp each sample, then fold it into the window max (first sample of a window loads).
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign samp[k] = (RELU_EN && in_vec[k][DW-1]) ? '0 : in_vec[k];
    assign cand[k] = ((wcnt_q == '0) || ($signed(samp[k]) > $signed(max_q[k])))
                     ? samp[k] : max_q[k];
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ocnt_d    = ocnt_q;
    max_d     = max_q;
    out4_d    = out4_q;
    maxflag_d = 1'b0;
    done4_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          wcnt_d  = '0;
          ocnt_d  = '0;
          max_d   = '0;
        end
      end
      RUN: begin
        // A start here aborts the frame and drops this cycle's sample.
        if (start) begin
          wcnt_d = '0;
          ocnt_d = '0;
          max_d  = '0;
        end else if (in_valid) begin
          max_d = cand;
          if (wcnt_q == WLAST) begin
            wcnt_d    = '0;
            out4_d    = cand;
            maxflag_d = 1'b1;
            if (ocnt_q == OLAST) begin
              ocnt_d  = '0;
              state_d = DONE;
            end else begin
              ocnt_d = ocnt_q + OCW'(1);
            end
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done4_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      ocnt_q    <= '0;
      max_q     <= '0;
      out4_q    <= '0;
      maxflag_q <= 1'b0;
      done4_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ocnt_q    <= ocnt_d;
      max_q     <= max_d;
      out4_q    <= out4_d;
      maxflag_q <= maxflag_d;
      done4_q   <= done4_d;
      busy_q    <= busy_d;
    end
  end

  assign out4    = out4_q;
  assign maxflag = maxflag_q;
  assign done4   = done4_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_maxpool_stage4.sv
// Bench for maxpool_stage4: RELU=1 and RELU=0 instances on shared stimulus, checked
// every cycle against a window-list reference model plus table and corner sequences.
module tb_maxpool_stage4;

  localparam int unsigned TB_POOL = 2;
  localparam int unsigned TB_NOUT = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [127:0] in_data;
  logic [127:0] out4_r1, out4_r0;
  logic         mf1, mf0, dn1, dn0, bz1, bz0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  maxpool_stage4 #(.POOL(TB_POOL), .NUM_OUT(TB_NOUT), .RELU(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out4(out4_r1), .maxflag(mf1), .done4(dn1), .busy(bz1)
  );

  maxpool_stage4 #(.POOL(TB_POOL), .NUM_OUT(TB_NOUT), .RELU(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out4(out4_r0), .maxflag(mf0), .done4(dn0), .busy(bz0)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    check(name, 128'(act), 128'(exp));
  endtask

  // Reference model: index 0 = RELU off, index 1 = RELU on.
  bit           m_active [2];
  bit           m_donep  [2];
  int           m_nwin   [2];
  int           m_nout   [2];
  logic [127:0] m_win    [2][TB_POOL];
  logic [127:0] e_out4   [2];
  bit           e_mf     [2];
  bit           e_dn     [2];
  bit           e_bz     [2];

  task automatic model_reset(int i);
    m_active[i] = 0; m_donep[i] = 0; m_nwin[i] = 0; m_nout[i] = 0;
    e_out4[i] = '0; e_mf[i] = 0; e_dn[i] = 0; e_bz[i] = 0;
  endtask

  function automatic logic [127:0] win_max(int i, bit relu);
    logic [127:0]      r;
    logic signed [7:0] b;
    int                v;
    int                best;
    r = '0;
    for (int ch = 0; ch < 16; ch++) begin
      best = -1000;
      for (int s = 0; s < m_nwin[i]; s++) begin
        b = m_win[i][s][ch*8 +: 8];
        v = int'(b);
        if (relu && v < 0) v = 0;
        if (v > best) best = v;
      end
      r[ch*8 +: 8] = 8'(best);
    end
    return r;
  endfunction

  task automatic model_step(int i, bit relu);
    e_mf[i] = 0;
    e_dn[i] = 0;
    if (m_donep[i]) begin
      m_donep[i] = 0;
      e_dn[i]    = 1;
    end else if (start) begin
      m_active[i] = 1; m_nwin[i] = 0; m_nout[i] = 0;
    end else if (m_active[i] && in_valid) begin
      m_win[i][m_nwin[i]] = in_data;
      m_nwin[i]++;
      if (m_nwin[i] == int'(TB_POOL)) begin
        e_out4[i] = win_max(i, relu);
        e_mf[i]   = 1;
        m_nwin[i] = 0;
        m_nout[i]++;
        if (m_nout[i] == int'(TB_NOUT)) begin
          m_active[i] = 0;
          m_donep[i]  = 1;
        end
      end
    end
    e_bz[i] = m_active[i];
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("out4_relu1", out4_r1, e_out4[1]);
      check1("maxflag_relu1", mf1, e_mf[1]);
      check1("done4_relu1", dn1, e_dn[1]);
      check1("busy_relu1", bz1, e_bz[1]);
      check("out4_relu0", out4_r0, e_out4[0]);
      check1("maxflag_relu0", mf0, e_mf[0]);
      check1("done4_relu0", dn0, e_dn[0]);
      check1("busy_relu0", bz0, e_bz[0]);
    end
  end

  int mf_cnt = 0;
  int dn_cnt = 0;
  int mf0_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (mf1) mf_cnt++;
    if (dn1) dn_cnt++;
    if (mf0) mf0_cnt++;
  end

  task automatic drive(bit st, bit iv, logic [127:0] d);
    start    = st;
    in_valid = iv;
    in_data  = d;
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    bit         st;
    bit         iv;
    logic [7:0] d0;
    bit         mf;
    bit         dn;
    bit         bz;
    logic [7:0] o0;
  } vec_t;

  function automatic vec_t mkv(bit st, bit iv, logic [7:0] d0, bit mf, bit dn, bit bz,
                               logic [7:0] o0);
    vec_t v;
    v.st = st; v.iv = iv; v.d0 = d0; v.mf = mf; v.dn = dn; v.bz = bz; v.o0 = o0;
    return v;
  endfunction

  vec_t         tbl [12];
  logic [127:0] d;

  initial begin
    model_reset(0);
    model_reset(1);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_out4", out4_r1, '0);
    check1("reset_maxflag", mf1, 1'b0);
    check1("reset_done4", dn1, 1'b0);
    check1("reset_busy", bz1, 1'b0);
    rst    = 1'b1;
    chk_en = 1;

    // Frame of 8 back-to-back vectors on ch0, then start/in_valid in DONE and IDLE.
    tbl[0]  = mkv(1, 0, 8'd0,   0, 0, 0, 8'd0);
    tbl[1]  = mkv(0, 1, 8'd5,   0, 0, 1, 8'd0);
    tbl[2]  = mkv(0, 1, 8'd9,   0, 0, 1, 8'd0);
    tbl[3]  = mkv(0, 1, 8'hFD,  1, 0, 1, 8'd9);
    tbl[4]  = mkv(0, 1, 8'hF9,  0, 0, 1, 8'd9);
    tbl[5]  = mkv(0, 1, 8'd100, 1, 0, 1, 8'd0);
    tbl[6]  = mkv(0, 1, 8'd127, 0, 0, 1, 8'd0);
    tbl[7]  = mkv(0, 1, 8'd0,   1, 0, 1, 8'd127);
    tbl[8]  = mkv(0, 1, 8'd1,   0, 0, 1, 8'd127);
    tbl[9]  = mkv(1, 1, 8'h55,  1, 0, 0, 8'd1);
    tbl[10] = mkv(0, 1, 8'h7F,  0, 1, 0, 8'd1);
    tbl[11] = mkv(0, 1, 8'h33,  0, 0, 0, 8'd1);
    for (int k = 0; k < 12; k++) begin
      check1($sformatf("tbl%0d_maxflag", k), mf1, tbl[k].mf);
      check1($sformatf("tbl%0d_done4", k), dn1, tbl[k].dn);
      check1($sformatf("tbl%0d_busy", k), bz1, tbl[k].bz);
      check($sformatf("tbl%0d_ch0", k), 128'(out4_r1[7:0]), 128'(tbl[k].o0));
      drive(tbl[k].st, tbl[k].iv, {120'd0, tbl[k].d0});
    end

    // RELU off: -128 vs -1 on ch15 must pool to -1.
    mf0_cnt = 0;
    drive(1, 0, '0);
    d = rnd(); d[127:120] = 8'h80;
    drive(0, 1, d);
    d = rnd(); d[127:120] = 8'hFF;
    drive(0, 1, d);
    check("relu0_ch15", 128'(out4_r0[127:120]), 128'(8'hFF));
    check1("relu0_maxflag", mf0, 1'b1);
    check("relu0_mf_count", 128'(mf0_cnt), 128'(1));
    for (int k = 0; k < 6; k++) drive(0, 1, rnd());
    for (int k = 0; k < 3; k++) drive(0, 0, rnd());

    // Window split by a two-cycle in_valid gap.
    drive(1, 0, '0);
    mf_cnt = 0;
    drive(0, 1, rnd());
    drive(0, 0, rnd());
    drive(0, 0, rnd());
    check("gap_no_early_mf", 128'(mf_cnt), 128'(0));
    drive(0, 1, rnd());
    check1("gap_maxflag", mf1, 1'b1);
    check("gap_mf_count", 128'(mf_cnt), 128'(1));
    for (int k = 0; k < 6; k++) drive(0, 1, rnd());
    for (int k = 0; k < 3; k++) drive(0, 0, rnd());

    // Restart after three accepted samples.
    drive(1, 0, '0);
    for (int k = 0; k < 3; k++) drive(0, 1, rnd());
    mf_cnt = 0;
    dn_cnt = 0;
    drive(1, 1, rnd());
    for (int k = 0; k < 8; k++) drive(0, 1, rnd());
    for (int k = 0; k < 3; k++) drive(0, 0, rnd());
    check("restart_mf_count", 128'(mf_cnt), 128'(4));
    check("restart_done_count", 128'(dn_cnt), 128'(1));

    // Asynchronous reset mid-frame, then valids without start.
    drive(1, 0, '0);
    for (int k = 0; k < 3; k++) drive(0, 1, rnd());
    #2 rst = 1'b0;
    #1;
    check("rst_out4_relu1", out4_r1, '0);
    check("rst_out4_relu0", out4_r0, '0);
    check1("rst_maxflag", mf1, 1'b0);
    check1("rst_done4", dn1, 1'b0);
    check1("rst_busy", bz1, 1'b0);
    @(negedge clk);
    rst    = 1'b1;
    mf_cnt = 0;
    for (int k = 0; k < 5; k++) drive(0, 1, rnd());
    check("post_rst_mf_count", 128'(mf_cnt), 128'(0));
    check1("post_rst_busy", bz1, 1'b0);

    // Valids in IDLE must not produce pooled output.
    mf_cnt = 0;
    for (int k = 0; k < 4; k++) drive(0, 1, rnd());
    check("idle_mf_count", 128'(mf_cnt), 128'(0));

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), rnd());
    end
    for (int k = 0; k < 4; k++) drive(0, 0, '0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/maxpool_stage4.md
MAXPOOL_STAGE4 -- requirements
Module: maxpool_stage4

Interface
REQ-001 SHALL have parameter POOL, default 2: window length and stride in samples.
REQ-002 SHALL have parameter NUM_OUT, default 4: pooled vectors per frame.
REQ-003 SHALL have parameter RELU, default 1: when 1, negative samples clamp to 0 before comparison.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that arms a new frame.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds one conv-4 sample vector this cycle.
REQ-008 SHALL have port in_data, input, 128 bits: 16 signed 8-bit channels; channel k at bits [8k+7:8k].
REQ-009 SHALL have port out4, output, 128 bits: 16 signed 8-bit pooled channels, same packing as in_data.
REQ-010 SHALL have port maxflag, output, 1 bit: one-cycle pulse marking a new valid out4.
REQ-011 SHALL have port done4, output, 1 bit: one-cycle pulse marking frame complete.
REQ-012 SHALL have port busy, output, 1 bit: high while state is RUN.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 SHALL transition IDLE->RUN on start.
REQ-015 SHALL transition RUN->DONE on the cycle that emits pooled vector NUM_OUT.
REQ-016 SHALL transition DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL keep a window counter wcnt (0..POOL-1) and an output counter ocnt (0..NUM_OUT-1).
REQ-018 SHALL, in RUN with in_valid=1 and wcnt=0, load each channel's running max with its (post-RELU) sample.
REQ-019 SHALL, in RUN with in_valid=1 and wcnt>0, set running max = signed max(running max, sample) per channel.
REQ-020 SHALL, when the sample at wcnt=POOL-1 is accepted, register the final max into out4, pulse maxflag on the next cycle, reset wcnt to 0 and increment ocnt.
REQ-021 SHALL give maxflag a latency of exactly 1 cycle after the accepting edge of the last window sample.
REQ-022 SHALL hold out4 stable between maxflag pulses and through IDLE until the next maxflag.
REQ-023 SHALL pulse done4 in DONE, exactly one cycle after the final maxflag and never in the same cycle as it.
REQ-024 SHALL allow in_valid gaps of any length; counters and running max hold while in_valid=0.
REQ-025 SHALL ignore in_valid in IDLE and DONE; no counter or out4 change.
REQ-026 SHALL, on start in RUN, restart the frame: wcnt=0, ocnt=0, running max discarded, no maxflag/done4 for the aborted frame; that cycle's in_valid sample is dropped.
REQ-027 SHALL ignore start in DONE; a new frame requires start in IDLE.
REQ-028 SHALL, for RELU=0, compare raw signed values, e.g. max(-128, -1) = -1.
REQ-029 SHALL perform no arithmetic beyond compare/clamp; output width equals input width with no saturation logic.

Reset
REQ-030 SHALL, while rst=0, force state=IDLE, wcnt=0, ocnt=0, out4=0, maxflag=0, done4=0, busy=0 and running max=0, asynchronously.
REQ-031 SHALL, on rst assertion mid-frame, discard the partial frame; the first frame after release requires a fresh start.

Verification
REQ-032 SHALL cover: POOL=2, NUM_OUT=4, RELU=1, start then 8 back-to-back vectors with ch0 = 5,9,-3,-7,100,127,0,1 -> maxflag at cycles 3,5,7,9 after first valid; ch0 out = 9,0,127,1; done4 at cycle 10.
REQ-033 SHALL cover: RELU=0, ch15 samples -128,-1 -> out4[127:120]=8'hFF, maxflag once.
REQ-034 SHALL cover: in_valid toggled 1,0,0,1 across a window -> single maxflag 1 cycle after the second valid; max correct.
REQ-035 SHALL cover: start reasserted after 3 accepted samples -> no maxflag for the old frame; the next 8 samples yield 4 maxflags and 1 done4.
REQ-036 SHALL cover: rst low for 1 cycle mid-frame -> all outputs 0 immediately; post-reset in_valid without start -> no maxflag.
REQ-037 SHALL cover: in_valid pulses in IDLE and DONE -> out4 unchanged, no maxflag.
